// File: rtl/tank_level_if.sv
// tank_level_if
//   Sensor/valve bundle between the tank controller (master) and the tank
//   plant model (slave).
//   ve, dr, clr : controller -> tank (valve open, outlet draw, flag clear)
//   l, m, h     : tank -> controller level sensors (thermometer code)
//   level       : current water level, W bits
//   ovf, dry    : sticky fault flags
interface tank_level_if #(
  parameter int W = 8
);
  logic         ve;
  logic         dr;
  logic         clr;
  logic         l;
  logic         m;
  logic         h;
  logic [W-1:0] level;
  logic         ovf;
  logic         dry;

  modport master (output ve, dr, clr, input l, m, h, level, ovf, dry);
  modport slave  (input ve, dr, clr, output l, m, h, level, ovf, dry);
endinterface

// File: rtl/tank_level_emulator.sv
// tank_level_emulator
//   Cycle-accurate water tank plant. Integrates the inlet valve (ve) and
//   outlet draw (dr) through two prescalers into a saturating level register
//   and drives the l/m/h level sensors back to the controller.
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset
//   tif   : slave side of tank_level_if (ve/dr/clr in; l/m/h/level/ovf/dry out)
module tank_level_emulator #(
  parameter int W          = 8,
  parameter int CAP        = 255,
  parameter int INIT_LEVEL = 0,
  parameter int L_TH       = 32,
  parameter int M_TH       = 128,
  parameter int H_TH       = 224,
  parameter int FILL_DIV   = 4,
  parameter int DRAIN_DIV  = 8
) (
  input logic          clk,
  input logic          rst_n,
  tank_level_if.slave  tif
);

  localparam int FW = (FILL_DIV  > 1) ? $clog2(FILL_DIV)  : 1;
  localparam int DW = (DRAIN_DIV > 1) ? $clog2(DRAIN_DIV) : 1;

  localparam logic [W-1:0] CAP_V  = W'(CAP);
  localparam logic [W-1:0] INIT_V = W'(INIT_LEVEL);

  logic [FW-1:0] fcnt;
  logic [DW-1:0] dcnt;
  logic          ft, dt;
  logic [W-1:0]  level_q, level_nx;
  logic          ovf_q, dry_q, ovf_set, dry_set;
  logic          l_q, m_q, h_q;

  // A tick fires on the last count of a continuous run; dropping the input
  // discards partial progress.
  assign ft = tif.ve && (fcnt == FW'(FILL_DIV - 1));
  assign dt = tif.dr && (dcnt == DW'(DRAIN_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt <= '0;
      dcnt <= '0;
    end else begin
      fcnt <= (!tif.ve || ft) ? '0 : fcnt + FW'(1);
      dcnt <= (!tif.dr || dt) ? '0 : dcnt + DW'(1);
    end
  end

  // Saturating level update; simultaneous ticks cancel without raising flags.
  always_comb begin
    level_nx = level_q;
    ovf_set  = 1'b0;
    dry_set  = 1'b0;
    case ({ft, dt})
      2'b10: begin
        if (level_q < CAP_V) level_nx = level_q + W'(1);
        else                 ovf_set  = 1'b1;
      end
      2'b01: begin
        if (level_q != '0) level_nx = level_q - W'(1);
        else               dry_set  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= INIT_V;
      ovf_q   <= 1'b0;
      dry_q   <= 1'b0;
      l_q     <= (INIT_LEVEL >= L_TH);
      m_q     <= (INIT_LEVEL >= M_TH);
      h_q     <= (INIT_LEVEL >= H_TH);
    end else begin
      level_q <= level_nx;
      // set beats clear when both happen in the same cycle
      ovf_q   <= ovf_set | (ovf_q & ~tif.clr);
      dry_q   <= dry_set | (dry_q & ~tif.clr);
      // sensors follow the next level so they move on the same edge as level
      l_q     <= (level_nx >= W'(L_TH));
      m_q     <= (level_nx >= W'(M_TH));
      h_q     <= (level_nx >= W'(H_TH));
    end
  end

  assign tif.level = level_q;
  assign tif.ovf   = ovf_q;
  assign tif.dry   = dry_q;
  assign tif.l     = l_q;
  assign tif.m     = m_q;
  assign tif.h     = h_q;

endmodule

// File: tb/tb_tank_level_emulator.sv
// tb_tank_level_emulator
//   Directed bench for tank_level_emulator with a run-length based tank model
//   compared every cycle, plus literal expectations from the test plan.
module tb_tank_level_emulator;

  localparam int W = 8, CAP = 255, INIT = 0;
  localparam int L_TH = 32, M_TH = 128, H_TH = 224;
  localparam int FDIV = 4, DDIV = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tank_level_if #(.W(W)) tif ();

  tank_level_emulator #(
    .W(W), .CAP(CAP), .INIT_LEVEL(INIT), .L_TH(L_TH), .M_TH(M_TH),
    .H_TH(H_TH), .FILL_DIV(FDIV), .DRAIN_DIV(DDIV)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .tif   (tif)
  );

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a tick happens whenever the length of the current continuous
  // ve (or dr) run reaches a multiple of the divider.
  int  m_lvl, m_frun, m_drun;
  bit  m_ovf, m_dry;

  always @(posedge clk or negedge rst_n) begin
    int  fr, dr;
    bit  f, d, so, sd;
    int  nl;
    if (!rst_n) begin
      m_lvl  <= INIT;
      m_frun <= 0;
      m_drun <= 0;
      m_ovf  <= 1'b0;
      m_dry  <= 1'b0;
    end else begin
      fr = tif.ve ? m_frun + 1 : 0;
      dr = tif.dr ? m_drun + 1 : 0;
      f  = tif.ve && (fr % FDIV == 0);
      d  = tif.dr && (dr % DDIV == 0);
      nl = m_lvl;
      so = 1'b0;
      sd = 1'b0;
      if (f && !d) begin
        if (m_lvl == CAP) so = 1'b1; else nl = m_lvl + 1;
      end
      if (d && !f) begin
        if (m_lvl == 0) sd = 1'b1; else nl = m_lvl - 1;
      end
      m_frun <= fr;
      m_drun <= dr;
      m_lvl  <= nl;
      m_ovf  <= so || (m_ovf && !tif.clr);
      m_dry  <= sd || (m_dry && !tif.clr);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("level", int'(tif.level), m_lvl);
      chk("l", int'(tif.l), int'(m_lvl >= L_TH));
      chk("m", int'(tif.m), int'(m_lvl >= M_TH));
      chk("h", int'(tif.h), int'(m_lvl >= H_TH));
      chk("ovf", int'(tif.ovf), int'(m_ovf));
      chk("dry", int'(tif.dry), int'(m_dry));
    end
  end

  // Advance n rising edges, land 1 time unit after the last one.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tif.ve = 1'b0; tif.dr = 1'b0; tif.clr = 1'b0;
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
  endtask

  initial begin
    tif.ve = 1'b0; tif.dr = 1'b0; tif.clr = 1'b0;
    #2 chk_en = 1'b1;
    cyc(3);
    rst_n = 1'b1;

    // reset state
    chk("rst_level", int'(tif.level), 0);
    chk("rst_lmh", int'({tif.l, tif.m, tif.h}), 0);
    chk("rst_flags", int'({tif.ovf, tif.dry}), 0);

    // fill to full and overflow
    tif.ve = 1'b1;
    cyc(128);
    chk("fill_e128_level", int'(tif.level), 32);
    chk("fill_e128_lmh", int'({tif.l, tif.m, tif.h}), 3'b100);
    cyc(383);
    chk("fill_e511_m", int'(tif.m), 0);
    cyc(1);
    chk("fill_e512_m", int'(tif.m), 1);
    cyc(383);
    chk("fill_e895_h", int'(tif.h), 0);
    cyc(1);
    chk("fill_e896_h", int'(tif.h), 1);
    cyc(124);
    chk("fill_e1020_level", int'(tif.level), 255);
    chk("fill_e1020_ovf", int'(tif.ovf), 0);
    cyc(4);
    chk("fill_e1024_level", int'(tif.level), 255);
    chk("fill_e1024_ovf", int'(tif.ovf), 1);
    tif.ve = 1'b0; tif.clr = 1'b1;
    cyc(1);
    tif.clr = 1'b0;
    chk("ovf_cleared", int'(tif.ovf), 0);

    // dry run and clear priority
    do_reset();
    tif.dr = 1'b1;
    cyc(8);
    chk("dry_e8", int'(tif.dry), 1);
    chk("dry_e8_level", int'(tif.level), 0);
    cyc(7);
    tif.clr = 1'b1;
    cyc(1);
    chk("dry_set_wins", int'(tif.dry), 1);
    cyc(1);
    tif.clr = 1'b0;
    chk("dry_clr_no_tick", int'(tif.dry), 0);
    tif.dr = 1'b0;

    // simultaneous fill and drain from 100
    do_reset();
    tif.ve = 1'b1;
    cyc(400);
    tif.ve = 1'b0;
    cyc(1);
    chk("sim_start", int'(tif.level), 100);
    tif.ve = 1'b1; tif.dr = 1'b1;
    cyc(4);
    chk("sim_e4", int'(tif.level), 101);
    cyc(4);
    chk("sim_e8", int'(tif.level), 101);
    cyc(4);
    chk("sim_e12", int'(tif.level), 102);
    cyc(4);
    chk("sim_e16", int'(tif.level), 102);
    chk("sim_flags", int'({tif.ovf, tif.dry}), 0);
    tif.ve = 1'b0; tif.dr = 1'b0;

    // prescaler restart from 50
    do_reset();
    tif.ve = 1'b1;
    cyc(200);
    tif.ve = 1'b0;
    cyc(1);
    chk("pre_start", int'(tif.level), 50);
    tif.ve = 1'b1;
    cyc(3);
    tif.ve = 1'b0;
    cyc(1);
    chk("pre_partial", int'(tif.level), 50);
    tif.ve = 1'b1;
    cyc(3);
    chk("pre_e3", int'(tif.level), 50);
    cyc(1);
    chk("pre_e4", int'(tif.level), 51);

    // async reset mid-fill from 200
    do_reset();
    tif.ve = 1'b1;
    cyc(800);
    chk("ar_start", int'(tif.level), 200);
    chk("ar_start_lmh", int'({tif.l, tif.m, tif.h}), 3'b110);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_level", int'(tif.level), 0);
    chk("ar_lmh", int'({tif.l, tif.m, tif.h}), 0);
    tif.ve = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(2);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
